// File: rtl/nor_cmd_seq_if.sv
// rtl/nor_cmd_seq_if.sv - command request and wishbone master signal bundle for nor_cmd_seq
interface nor_cmd_seq_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_op_i;
  logic [ADDRBITS-1:0] cmd_adr_i;
  logic [DATABITS-1:0] cmd_dat_i;
  logic                busy_o;
  logic                done_o;
  logic [1:0]          status_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [ADDRBITS-1:0] wb_adr_o;
  logic [DATABITS-1:0] wb_dat_o;
  logic [DATABITS-1:0] wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;
  logic                wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    output cmd_ready_o, busy_o, done_o, status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    input  cmd_ready_o, busy_o, done_o, status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/nor_cmd_seq.sv
// rtl/nor_cmd_seq.sv - expands one JEDEC NOR command into wishbone unlock writes,
// then polls DQ6 toggle until the embedded operation completes, times out or errors.
module nor_cmd_seq #(
  parameter int ADDRBITS     = 26,
  parameter int DATABITS     = 16,
  parameter int TIMEOUT_BITS = 24
) (
  input logic            clk_i,
  input logic            reset_i,
  nor_cmd_seq_if.master  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [1:0] OP_PROG = 2'b00, OP_SECT = 2'b01, OP_CHIP = 2'b10, OP_RST = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_TMO = 2'b01, ST_ERR = 2'b10;

  localparam logic [ADDRBITS-1:0] A_555 = ADDRBITS'(12'h555);
  localparam logic [ADDRBITS-1:0] A_2AA = ADDRBITS'(12'h2AA);
  localparam logic [DATABITS-1:0] D_AA = DATABITS'(8'hAA);
  localparam logic [DATABITS-1:0] D_55 = DATABITS'(8'h55);
  localparam logic [DATABITS-1:0] D_A0 = DATABITS'(8'hA0);
  localparam logic [DATABITS-1:0] D_80 = DATABITS'(8'h80);
  localparam logic [DATABITS-1:0] D_30 = DATABITS'(8'h30);
  localparam logic [DATABITS-1:0] D_10 = DATABITS'(8'h10);
  localparam logic [DATABITS-1:0] D_F0 = DATABITS'(8'hF0);

  state_t                  state, state_n;
  logic [1:0]              op;
  logic [ADDRBITS-1:0]     adr;
  logic [DATABITS-1:0]     dat;
  logic [2:0]              step;
  logic [TIMEOUT_BITS-1:0] timer;
  logic                    primed, last_dq6, match;
  logic [1:0]              status, fin_status;
  logic [ADDRBITS-1:0]     list_adr, poll_adr;
  logic [DATABITS-1:0]     list_dat;
  logic                    list_last;
  logic                    wr_phase, rd_phase, in_poll, timed_out;

  // Unlock write table indexed by the latched op and current step.
  always_comb begin
    list_adr  = A_555;
    list_dat  = D_AA;
    list_last = 1'b0;
    case (op)
      OP_RST: begin
        list_adr  = adr;
        list_dat  = D_F0;
        list_last = 1'b1;
      end
      OP_PROG: begin
        case (step)
          3'd0: ;
          3'd1: begin list_adr = A_2AA; list_dat = D_55; end
          3'd2: list_dat = D_A0;
          default: begin list_adr = adr; list_dat = dat; list_last = 1'b1; end
        endcase
      end
      default: begin
        case (step)
          3'd0, 3'd3: ;
          3'd1, 3'd4: begin list_adr = A_2AA; list_dat = D_55; end
          3'd2: list_dat = D_80;
          default: begin
            list_last = 1'b1;
            if (op == OP_SECT) begin
              list_adr = adr;
              list_dat = D_30;
            end else begin
              list_dat = D_10;
            end
          end
        endcase
      end
    endcase
  end

  assign poll_adr  = (op == OP_CHIP) ? '0 : adr;
  assign wr_phase  = (state == S_WR) || (state == S_WR_WAIT);
  assign rd_phase  = (state == S_RD) || (state == S_RD_WAIT);
  assign in_poll   = rd_phase || (state == S_CHECK);
  assign timed_out = &timer;

  always_comb begin
    state_n    = state;
    fin_status = ST_OK;
    case (state)
      S_IDLE:    if (bus.cmd_valid_i) state_n = S_WR;
      S_WR:      if (!bus.wb_stall_i) state_n = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.wb_err_i) begin
          state_n    = S_DONE;
          fin_status = ST_ERR;
        end else if (bus.wb_ack_i) begin
          if (!list_last)        state_n = S_WR;
          else if (op == OP_RST) state_n = S_DONE;
          else                   state_n = S_RD;
        end
      end
      S_RD:      if (!bus.wb_stall_i) state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.wb_err_i) begin
          state_n    = S_DONE;
          fin_status = ST_ERR;
        end else if (bus.wb_ack_i) begin
          state_n = S_CHECK;
        end
      end
      // Completion is tested before timeout so a finishing read reports ok.
      S_CHECK: begin
        if (match)          state_n = S_DONE;
        else if (timed_out) begin
          state_n    = S_DONE;
          fin_status = ST_TMO;
        end else            state_n = S_RD;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      op       <= 2'b00;
      adr      <= '0;
      dat      <= '0;
      step     <= 3'd0;
      timer    <= '0;
      primed   <= 1'b0;
      last_dq6 <= 1'b0;
      match    <= 1'b0;
      status   <= ST_OK;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.cmd_valid_i) begin
        op   <= bus.cmd_op_i;
        adr  <= bus.cmd_adr_i;
        dat  <= bus.cmd_dat_i;
        step <= 3'd0;
      end
      if (state == S_WR_WAIT && bus.wb_ack_i && !bus.wb_err_i && !list_last)
        step <= step + 3'd1;
      if (!in_poll) begin
        timer    <= '0;
        primed   <= 1'b0;
        last_dq6 <= 1'b0;
        match    <= 1'b0;
      end else begin
        if (!timed_out) timer <= timer + 1'b1;
        // First read only primes the DQ6 history.
        if (state == S_RD_WAIT && bus.wb_ack_i && !bus.wb_err_i) begin
          match    <= primed && (bus.wb_dat_i[6] == last_dq6);
          last_dq6 <= bus.wb_dat_i[6];
          primed   <= 1'b1;
        end
      end
      if (state_n == S_DONE) status <= fin_status;
    end
  end

  assign bus.cmd_ready_o = (state == S_IDLE);
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.done_o      = (state == S_DONE);
  assign bus.status_o    = status;
  assign bus.wb_cyc_o    = wr_phase || rd_phase;
  assign bus.wb_stb_o    = (state == S_WR) || (state == S_RD);
  assign bus.wb_we_o     = wr_phase;
  assign bus.wb_adr_o    = wr_phase ? list_adr : (rd_phase ? poll_adr : '0);
  assign bus.wb_dat_o    = wr_phase ? list_dat : '0;
endmodule

// File: tb/tb_nor_cmd_seq.sv
// tb/tb_nor_cmd_seq.sv - directed self-checking bench for nor_cmd_seq with a cycle-level wishbone slave
module tb_nor_cmd_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nor_cmd_seq_if #(.ADDRBITS(26), .DATABITS(16)) bus ();
  nor_cmd_seq #(.ADDRBITS(26), .DATABITS(16), .TIMEOUT_BITS(4)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  int          stall_left, err_at, txn_cnt, stb_after_err, first_stb_cycles, done_cnt;
  bit          pending, pending_rd, tog_mode, tog, after_err, err_prev, cyc_after_err_bad, first_unstable;
  logic [25:0] fa;
  logic [15:0] fd;
  logic [15:0] rd_q[$];
  logic [25:0] wr_adr_q[$];
  logic [15:0] wr_dat_q[$];
  logic [25:0] rd_adr_q[$];
  logic [1:0]  last_status;

  task automatic clear_log();
    stall_left = 0; err_at = 0; txn_cnt = 0; stb_after_err = 0; first_stb_cycles = 0; done_cnt = 0;
    pending = 0; pending_rd = 0; tog_mode = 0; tog = 0; after_err = 0; err_prev = 0;
    cyc_after_err_bad = 0; first_unstable = 0; fa = '0; fd = '0; last_status = 2'b00;
    rd_q.delete(); wr_adr_q.delete(); wr_dat_q.delete(); rd_adr_q.delete();
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_stall_i = 0; bus.wb_dat_i = '0;
  endtask

  // One clock of the slave: respond to the request accepted at the previous edge,
  // then decide stall / accept for the request visible now.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    if (bus.done_o) begin
      done_cnt++;
      last_status = bus.status_o;
    end
    if (err_prev && bus.wb_cyc_o !== 1'b0) cyc_after_err_bad = 1;
    if (after_err && bus.wb_stb_o) stb_after_err++;
    err_prev = 0;
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_dat_i = '0;
    if (pending) begin
      pending = 0;
      if (txn_cnt == err_at) begin
        bus.wb_err_i = 1; err_prev = 1; after_err = 1;
      end else begin
        bus.wb_ack_i = 1;
      end
      if (pending_rd) begin
        if (tog_mode) begin
          tog = ~tog;
          bus.wb_dat_i = {9'b0, tog, 6'b0};
        end else if (rd_q.size() > 0) begin
          bus.wb_dat_i = rd_q.pop_front();
        end
      end
    end
    bus.wb_stall_i = 0;
    if (bus.wb_stb_o) begin
      if (txn_cnt == 0) begin
        first_stb_cycles++;
        if (first_stb_cycles == 1) begin
          fa = bus.wb_adr_o; fd = bus.wb_dat_o;
        end else if (bus.wb_adr_o !== fa || bus.wb_dat_o !== fd) begin
          first_unstable = 1;
        end
      end
      if (stall_left > 0) begin
        bus.wb_stall_i = 1;
        stall_left--;
      end else begin
        txn_cnt++;
        pending = 1;
        pending_rd = !bus.wb_we_o;
        if (bus.wb_we_o) begin
          wr_adr_q.push_back(bus.wb_adr_o);
          wr_dat_q.push_back(bus.wb_dat_o);
        end else begin
          rd_adr_q.push_back(bus.wb_adr_o);
        end
      end
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [25:0] a, input logic [15:0] d,
                           output logic stb_next);
    for (int i = 0; i < 5 && !bus.cmd_ready_o; i++) run_cycle();
    bus.cmd_valid_i = 1; bus.cmd_op_i = op; bus.cmd_adr_i = a; bus.cmd_dat_i = d;
    run_cycle();
    stb_next = bus.wb_stb_o;
    bus.cmd_valid_i = 0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      run_cycle();
      if (done_cnt != start) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [25:0] ea [6], input logic [15:0] ed [6]);
    checks++;
    if (wr_adr_q.size() != n) begin
      errors++;
      $display("FAIL %s write count got %0d exp %0d", name, wr_adr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_adr_q[i] !== ea[i] || wr_dat_q[i] !== ed[i]) begin
          errors++;
          $display("FAIL %s write%0d got %h/%h exp %h/%h", name, i, wr_adr_q[i], wr_dat_q[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    clear_log();
    repeat (3) run_cycle();
    checks++;
    if ({bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.status_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10000000",
               {bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.status_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o});
    end
    checks++;
    if (bus.wb_adr_o !== 26'h0 || bus.wb_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h exp 0/0", bus.wb_adr_o, bus.wb_dat_o);
    end
    rst = 0;
  endtask

  task automatic test_program();
    logic s;
    logic [25:0] ea [6] = '{26'h555, 26'h2AA, 26'h555, 26'h12345, 26'h0, 26'h0};
    logic [15:0] ed [6] = '{16'h00AA, 16'h0055, 16'h00A0, 16'hBEEF, 16'h0, 16'h0};
    clear_log();
    rd_q = {16'h0040, 16'h0000, 16'h0040, 16'h0040};
    issue_cmd(2'b00, 26'h12345, 16'hBEEF, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL prog_first_stb got %b exp 1", s); end
    wait_done(60);
    check_writes("prog", 4, ea, ed);
    checks++;
    if (rd_adr_q.size() != 4) begin errors++; $display("FAIL prog_reads got %0d exp 4", rd_adr_q.size()); end
    checks++;
    if (rd_adr_q.size() > 0 && rd_adr_q[0] !== 26'h12345) begin
      errors++; $display("FAIL prog_poll_adr got %h exp 12345", rd_adr_q[0]);
    end
    checks++;
    if (last_status !== 2'b00) begin errors++; $display("FAIL prog_status got %b exp 00", last_status); end
    run_cycle();
    checks++;
    if ({bus.done_o, bus.busy_o, bus.cmd_ready_o} !== 3'b001 || done_cnt != 1) begin
      errors++;
      $display("FAIL prog_done_pulse got %b cnt %0d exp 001 cnt 1", {bus.done_o, bus.busy_o, bus.cmd_ready_o}, done_cnt);
    end
  endtask

  task automatic test_sector();
    logic s;
    logic [25:0] ea [6] = '{26'h555, 26'h2AA, 26'h555, 26'h555, 26'h2AA, 26'h20000};
    logic [15:0] ed [6] = '{16'h00AA, 16'h0055, 16'h0080, 16'h00AA, 16'h0055, 16'h0030};
    clear_log();
    issue_cmd(2'b01, 26'h20000, 16'hFFFF, s);
    wait_done(60);
    check_writes("sector", 6, ea, ed);
    checks++;
    if (rd_adr_q.size() != 2 || rd_adr_q[0] !== 26'h20000) begin
      errors++; $display("FAIL sector_poll got %0d reads exp 2 at 20000", rd_adr_q.size());
    end
    checks++;
    if (last_status !== 2'b00) begin errors++; $display("FAIL sector_status got %b exp 00", last_status); end
    run_cycle();
  endtask

  task automatic test_chip();
    logic s;
    logic [25:0] ea [6] = '{26'h555, 26'h2AA, 26'h555, 26'h555, 26'h2AA, 26'h555};
    logic [15:0] ed [6] = '{16'h00AA, 16'h0055, 16'h0080, 16'h00AA, 16'h0055, 16'h0010};
    clear_log();
    issue_cmd(2'b10, 26'h3FFFF, 16'h1111, s);
    wait_done(60);
    check_writes("chip", 6, ea, ed);
    checks++;
    if (rd_adr_q.size() != 2 || rd_adr_q[0] !== 26'h0) begin
      errors++; $display("FAIL chip_poll got %0d reads exp 2 at 0", rd_adr_q.size());
    end
    run_cycle();
  endtask

  task automatic test_timeout();
    logic s;
    clear_log();
    tog_mode = 1;
    issue_cmd(2'b00, 26'h00100, 16'h5A5A, s);
    wait_done(100);
    checks++;
    if (last_status !== 2'b01) begin errors++; $display("FAIL timeout_status got %b exp 01", last_status); end
    checks++;
    if (rd_adr_q.size() != 6) begin errors++; $display("FAIL timeout_reads got %0d exp 6", rd_adr_q.size()); end
    run_cycle();
  endtask

  task automatic test_bus_error();
    logic s;
    clear_log();
    err_at = 2;
    issue_cmd(2'b01, 26'h10000, 16'h0, s);
    wait_done(40);
    checks++;
    if (last_status !== 2'b10) begin errors++; $display("FAIL err_status got %b exp 10", last_status); end
    checks++;
    if (wr_adr_q.size() != 2 || rd_adr_q.size() != 0) begin
      errors++; $display("FAIL err_txns got %0d wr %0d rd exp 2 wr 0 rd", wr_adr_q.size(), rd_adr_q.size());
    end
    repeat (4) run_cycle();
    checks++;
    if (stb_after_err != 0 || cyc_after_err_bad) begin
      errors++; $display("FAIL err_quiet got stb %0d cyc_bad %0d exp 0 0", stb_after_err, cyc_after_err_bad);
    end
    checks++;
    if (bus.status_o !== 2'b10) begin errors++; $display("FAIL err_status_held got %b exp 10", bus.status_o); end
  endtask

  task automatic test_stall();
    logic s;
    clear_log();
    stall_left = 3;
    issue_cmd(2'b00, 26'h00ABC, 16'h1234, s);
    wait_done(60);
    checks++;
    if (first_stb_cycles != 4 || first_unstable) begin
      errors++; $display("FAIL stall_hold got %0d cycles unstable %0d exp 4 0", first_stb_cycles, first_unstable);
    end
    checks++;
    if (wr_adr_q.size() != 4 || last_status !== 2'b00) begin
      errors++; $display("FAIL stall_result got %0d wr status %b exp 4 00", wr_adr_q.size(), last_status);
    end
    run_cycle();
  endtask

  task automatic test_busy_ignore();
    logic s;
    clear_log();
    issue_cmd(2'b00, 26'h00200, 16'hC0DE, s);
    repeat (3) run_cycle();
    bus.cmd_valid_i = 1; bus.cmd_op_i = 2'b11; bus.cmd_adr_i = 26'h0;
    run_cycle();
    bus.cmd_valid_i = 0;
    wait_done(60);
    repeat (3) run_cycle();
    checks++;
    if (done_cnt != 1 || wr_adr_q.size() != 4) begin
      errors++; $display("FAIL busy_ignore got done %0d wr %0d exp 1 4", done_cnt, wr_adr_q.size());
    end
    checks++;
    if (wr_dat_q.size() == 4 && wr_dat_q[3] !== 16'hC0DE) begin
      errors++; $display("FAIL busy_ignore_data got %h exp c0de", wr_dat_q[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic s;
    bit found;
    logic [25:0] ea [6] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0};
    logic [15:0] ed [6] = '{16'h00F0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    clear_log();
    found = 0;
    issue_cmd(2'b00, 26'h12345, 16'hBEEF, s);
    for (int i = 0; i < 30 && !found; i++) begin
      if (wr_adr_q.size() == 3 && bus.wb_stb_o) found = 1;
      else run_cycle();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach got 0 exp 1"); end
    rst = 1;
    run_cycle();
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready_o, bus.done_o} !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_state got %b exp 0010", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready_o, bus.done_o});
    end
    rst = 0;
    pending = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;
    repeat (2) run_cycle();
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt); end
    clear_log();
    issue_cmd(2'b11, 26'h0, 16'h1234, s);
    wait_done(20);
    check_writes("rstcmd", 1, ea, ed);
    checks++;
    if (rd_adr_q.size() != 0 || last_status !== 2'b00) begin
      errors++; $display("FAIL rstcmd_result got %0d rd status %b exp 0 00", rd_adr_q.size(), last_status);
    end
    run_cycle();
  endtask

  initial begin
    rst = 1;
    bus.cmd_valid_i = 0; bus.cmd_op_i = 2'b00; bus.cmd_adr_i = '0; bus.cmd_dat_i = '0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_stall_i = 0;
    test_reset();
    test_program();
    test_sector();
    test_chip();
    test_timeout();
    test_bus_error();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
